// File: rtl/rs_enc_pkg.sv
// Shared types and constants for the RS(544,522) GF(2^10) encoder sequencer.
package rs_enc_pkg;

    localparam int W      = 10;
    localparam int N_CW   = 544;
    localparam int K_MSG  = 522;
    localparam int R      = 22;
    localparam int IDX_W  = $clog2(K_MSG);
    localparam int PIDX_W = $clog2(R);

    typedef logic [W-1:0]      sym_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [PIDX_W-1:0] pidx_t;

    typedef enum logic {
        MSG = 1'b0,
        PAR = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/rs_enc_seq_ctrl_acc.sv
// rs_parity_acc: R x W parity register bank. A load replaces the bank with the
// incoming product (first symbol of a codeword), an accumulate XORs it in.
// GF(2^10) addition is plain XOR, so there is no carry or width growth.
module rs_parity_acc
    import rs_enc_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  clr_i,
    input  logic  load_i,
    input  logic  acc_i,
    input  sym_t  vec_v_i [0:R-1],
    input  pidx_t rd_idx_i,
    output sym_t  rd_data_o
);

    sym_t acc_q [0:R-1];

    // Bank update: clear, load on message index 0, otherwise XOR-accumulate.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int j = 0; j < R; j++) acc_q[j] <= '0;
        end else if (load_i) begin
            for (int j = 0; j < R; j++) acc_q[j] <= vec_v_i[j];
        end else if (acc_i) begin
            for (int j = 0; j < R; j++) acc_q[j] <= acc_q[j] ^ vec_v_i[j];
        end
    end

    assign rd_data_o = (rd_idx_i < pidx_t'(R)) ? acc_q[rd_idx_i] : '0;

endmodule

// File: rtl/rs_enc_seq_ctrl.sv
// rs_enc_seq_ctrl: feeds message symbols and K-ROM row addresses to the
// constant-multiply vector unit, accumulates parity, and emits the systematic
// codeword (522 message symbols, then 22 parity symbols, highest degree first)
// through a single registered output slot.
// Optional build macro RS_ENC_CTRL_ABORT_EN adds abort_i to drop a codeword.
//
// state | meaning
// MSG   | accepting message symbols, forwarding each to the output slot
// PAR   | input stalled, draining acc[R-1] .. acc[0] into the output slot
module rs_enc_seq_ctrl
    import rs_enc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
`ifdef RS_ENC_CTRL_ABORT_EN
    input  logic       abort_i,
`endif
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic [IDX_W-1:0] k_addr_o,
    output logic [W-1:0] vec_s_o,
    input  sym_t       vec_v_i [0:R-1],
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic       out_sop_o,
    output logic       out_eop_o,
    output logic       out_par_o
);

    ctrl_state_e state_q;
    idx_t        msg_idx_q;
    pidx_t       par_idx_q;
    logic        out_valid_q;
    sym_t        out_data_q;
    logic        out_sop_q;
    logic        out_eop_q;
    logic        out_par_q;

    logic        abort;
    logic        slot_free;
    logic        accept;
    sym_t        par_sym;

`ifdef RS_ENC_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign slot_free  = !out_valid_q || out_ready_i;
    assign in_ready_o = (state_q == MSG) && slot_free && !abort;
    assign accept     = in_valid_i && in_ready_o;
    assign k_addr_o   = msg_idx_q;
    assign vec_s_o    = in_data_i;

    rs_parity_acc u_acc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (abort),
        .load_i    (accept && (msg_idx_q == '0)),
        .acc_i     (accept),
        .vec_v_i   (vec_v_i),
        .rd_idx_i  (par_idx_q),
        .rd_data_o (par_sym)
    );

    // Sequencer FSM, index counters and the registered output slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= MSG;
            msg_idx_q   <= '0;
            par_idx_q   <= pidx_t'(R-1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_par_q   <= 1'b0;
        end else if (abort) begin
            state_q     <= MSG;
            msg_idx_q   <= '0;
            par_idx_q   <= pidx_t'(R-1);
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MSG: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= in_data_i;
                        out_sop_q   <= (msg_idx_q == '0);
                        out_eop_q   <= 1'b0;
                        out_par_q   <= 1'b0;
                        if (msg_idx_q == idx_t'(K_MSG-1)) begin
                            msg_idx_q <= '0;
                            state_q   <= PAR;
                        end else begin
                            msg_idx_q <= msg_idx_q + idx_t'(1);
                        end
                    end else if (slot_free) begin
                        out_valid_q <= 1'b0;
                    end
                end
                PAR: begin
                    if (slot_free) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= par_sym;
                        out_sop_q   <= 1'b0;
                        out_eop_q   <= (par_idx_q == '0);
                        out_par_q   <= 1'b1;
                        if (par_idx_q == '0) begin
                            par_idx_q <= pidx_t'(R-1);
                            state_q   <= MSG;
                        end else begin
                            par_idx_q <= par_idx_q - pidx_t'(1);
                        end
                    end
                end
                default: state_q <= MSG;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sop_o   = out_sop_q;
    assign out_eop_o   = out_eop_q;
    assign out_par_o   = out_par_q;

endmodule

// File: tb/tb_rs_enc_seq_ctrl.sv
// Bench for rs_enc_seq_ctrl. Plays the parent: holds the K-ROM and the
// combinational constant-multiply vector unit, and checks each codeword
// against an LFSR-division RS(544,522) encoder.
`timescale 1ns/1ps
module tb_rs_enc_seq_ctrl;
    import rs_enc_pkg::*;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
        logic         par;
    } beat_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [W-1:0]     in_data_i;
    logic [IDX_W-1:0] k_addr_o;
    logic [W-1:0]     vec_s_o;
    sym_t             vec_v_i [0:R-1];
    logic             out_valid_o;
    logic             out_ready_i;
    logic [W-1:0]     out_data_o;
    logic             out_sop_o;
    logic             out_eop_o;
    logic             out_par_o;
`ifdef RS_ENC_CTRL_ABORT_EN
    logic             abort_i = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    sym_t gpoly [0:R];
    sym_t krom  [0:K_MSG-1][0:R-1];

    rs_enc_seq_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
`ifdef RS_ENC_CTRL_ABORT_EN
        .abort_i     (abort_i),
`endif
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .k_addr_o    (k_addr_o),
        .vec_s_o     (vec_s_o),
        .vec_v_i     (vec_v_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_sop_o   (out_sop_o),
        .out_eop_o   (out_eop_o),
        .out_par_o   (out_par_o)
    );

    always #5 clk_i = ~clk_i;

    // GF(2^10) multiply, field polynomial x^10 + x^3 + 1
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t p;
        sym_t x;
        p = '0;
        x = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) p = p ^ x;
            x = x[W-1] ? ((x << 1) ^ sym_t'(10'h009)) : (x << 1);
        end
        return p;
    endfunction

    // Vector unit: product of the current symbol with the addressed K-ROM row
    always_comb begin
        for (int j = 0; j < R; j++) vec_v_i[j] = gf_mul(vec_s_o, krom[k_addr_o][j]);
    end

    // g(x) = prod_{i=0}^{R-1} (x + alpha^i); K-ROM row i = x^(R+K-1-i) mod g(x)
    task automatic build_tables();
        sym_t a;
        sym_t r [0:R-1];
        sym_t t;
        for (int j = 0; j <= R; j++) gpoly[j] = '0;
        gpoly[0] = sym_t'(1);
        a = sym_t'(1);
        for (int i = 0; i < R; i++) begin
            for (int j = R; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gf_mul(a, gpoly[j]);
            gpoly[0] = gf_mul(a, gpoly[0]);
            a = gf_mul(a, sym_t'(2));
        end
        for (int j = 0; j < R; j++) r[j] = gpoly[j];
        for (int j = 0; j < R; j++) krom[K_MSG-1][j] = r[j];
        for (int i = K_MSG-2; i >= 0; i--) begin
            t = r[R-1];
            for (int j = R-1; j > 0; j--) r[j] = r[j-1] ^ gf_mul(t, gpoly[j]);
            r[0] = gf_mul(t, gpoly[0]);
            for (int j = 0; j < R; j++) krom[i][j] = r[j];
        end
    endtask

    // Reference systematic encoder by polynomial long division (m_0 highest degree)
    function automatic void build_expected(input sym_t m [$], output beat_t e [$]);
        sym_t rem [0:R-1];
        sym_t fb;
        e = {};
        for (int j = 0; j < R; j++) rem[j] = '0;
        foreach (m[i]) begin
            e.push_back({m[i], (i == 0), 1'b0, 1'b0});
            fb = m[i] ^ rem[R-1];
            for (int j = R-1; j > 0; j--) rem[j] = rem[j-1] ^ gf_mul(fb, gpoly[j]);
            rem[0] = gf_mul(fb, gpoly[0]);
        end
        for (int j = R-1; j >= 0; j--) e.push_back({rem[j], 1'b0, (j == 0), 1'b1});
    endfunction

    function automatic void rand_msg(output sym_t m [$]);
        m = {};
        for (int i = 0; i < K_MSG; i++) m.push_back(sym_t'($urandom_range(1023)));
    endfunction

    // Stream driver/collector; called and returns just after a rising edge.
    task automatic drive(input sym_t msgs [$], input int n_beats, input int ready_pct,
                         input int valid_pct, output beat_t got [$], output int stall_err,
                         output int bubbles, output bit timeout);
        int    idx = 0;
        int    cyc = 0;
        bit    started = 1'b0;
        bit    prev_stall = 1'b0;
        bit    took;
        beat_t cur;
        beat_t prev;
        got = {};
        stall_err = 0;
        bubbles = 0;
        timeout = 1'b0;
        prev = '0;
        in_valid_i  = (msgs.size() > 0) && ($urandom_range(99) < valid_pct);
        in_data_i   = (msgs.size() > 0) ? msgs[0] : '0;
        out_ready_i = ($urandom_range(99) < ready_pct);
        forever begin
            @(negedge clk_i);
            cur = {out_data_o, out_sop_o, out_eop_o, out_par_o};
            if (prev_stall && (!out_valid_o || cur != prev)) stall_err++;
            prev_stall = out_valid_o && !out_ready_i;
            prev = cur;
            if (started && !out_valid_o) bubbles++;
            if (out_valid_o && out_ready_i) begin
                got.push_back(cur);
                started = 1'b1;
            end
            took = in_valid_i && in_ready_o;
            if (took) idx++;
            if (got.size() >= n_beats) break;
            cyc++;
            if (cyc > 20000) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
            if (idx < msgs.size()) begin
                if (took || !in_valid_i) begin
                    in_valid_i = ($urandom_range(99) < valid_pct);
                    in_data_i  = msgs[idx];
                end
            end else begin
                in_valid_i = 1'b0;
            end
            out_ready_i = ($urandom_range(99) < ready_pct);
        end
        @(posedge clk_i);
        #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got=%0b want=1", in_ready_o);
        else n_pass++;
        n_checks++;
        if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%0b want=0", out_valid_o);
        else n_pass++;
        n_checks++;
        if (k_addr_o !== '0) $display("FAIL reset_k_addr got=%0d want=0", k_addr_o);
        else n_pass++;
        n_checks++;
        if ({out_data_o, out_sop_o, out_eop_o, out_par_o} !== '0)
            $display("FAIL reset_out_fields got=%h want=0", {out_data_o, out_sop_o, out_eop_o, out_par_o});
        else n_pass++;
    endtask

    task automatic test_all_zero();
        sym_t  m [$];
        beat_t e [$];
        beat_t g [$];
        int se, bb;
        bit to;
        m = {};
        for (int i = 0; i < K_MSG; i++) m.push_back('0);
        build_expected(m, e);
        drive(m, N_CW, 100, 100, g, se, bb, to);
        n_checks++;
        if (to !== 1'b0 || g.size() !== N_CW) $display("FAIL zero_beats got=%0d want=%0d timeout=%0b", g.size(), N_CW, to);
        else n_pass++;
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            n_checks++;
            if (g[i] !== e[i]) $display("FAIL zero_beat[%0d] got=%h want=%h", i, g[i], e[i]);
            else n_pass++;
        end
        n_checks++;
        if (bb !== 0) $display("FAIL zero_bubbles got=%0d want=0", bb);
        else n_pass++;
    endtask

    task automatic test_unit_msg();
        sym_t  m [$];
        beat_t e [$];
        beat_t g [$];
        int se, bb;
        bit to;
        m = {};
        m.push_back(sym_t'(1));
        for (int i = 1; i < K_MSG; i++) m.push_back('0);
        build_expected(m, e);
        drive(m, N_CW, 100, 100, g, se, bb, to);
        n_checks++;
        if (to !== 1'b0 || g.size() !== N_CW) $display("FAIL unit_beats got=%0d want=%0d timeout=%0b", g.size(), N_CW, to);
        else n_pass++;
        for (int k = 0; k < R && (K_MSG + k) < g.size(); k++) begin
            n_checks++;
            if (g[K_MSG+k].data !== krom[0][R-1-k])
                $display("FAIL unit_krom_row0[%0d] got=%h want=%h", R-1-k, g[K_MSG+k].data, krom[0][R-1-k]);
            else n_pass++;
        end
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            n_checks++;
            if (g[i] !== e[i]) $display("FAIL unit_beat[%0d] got=%h want=%h", i, g[i], e[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        sym_t  m [$];
        beat_t e [$];
        beat_t g [$];
        int se, bb;
        bit to;
        rand_msg(m);
        build_expected(m, e);
        drive(m, N_CW, 50, 70, g, se, bb, to);
        n_checks++;
        if (to !== 1'b0 || g.size() !== N_CW) $display("FAIL bp_beats got=%0d want=%0d timeout=%0b", g.size(), N_CW, to);
        else n_pass++;
        n_checks++;
        if (se !== 0) $display("FAIL bp_stall_stable got=%0d changes want=0", se);
        else n_pass++;
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            n_checks++;
            if (g[i] !== e[i]) $display("FAIL bp_beat[%0d] got=%h want=%h", i, g[i], e[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        sym_t  m1 [$];
        sym_t  m2 [$];
        beat_t e1 [$];
        beat_t e2 [$];
        beat_t g [$];
        int se, bb;
        bit to;
        rand_msg(m1);
        rand_msg(m2);
        build_expected(m1, e1);
        build_expected(m2, e2);
        drive({m1, m2}, 2*N_CW, 100, 100, g, se, bb, to);
        n_checks++;
        if (to !== 1'b0 || g.size() !== 2*N_CW) $display("FAIL b2b_beats got=%0d want=%0d timeout=%0b", g.size(), 2*N_CW, to);
        else n_pass++;
        n_checks++;
        if (bb !== 0) $display("FAIL b2b_bubbles got=%0d want=0", bb);
        else n_pass++;
        e1 = {e1, e2};
        for (int i = 0; i < e1.size() && i < g.size(); i++) begin
            n_checks++;
            if (g[i] !== e1[i]) $display("FAIL b2b_beat[%0d] got=%h want=%h", i, g[i], e1[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        sym_t  m [$];
        beat_t e [$];
        beat_t g [$];
        int se, bb;
        bit to;
        rand_msg(m);
        m = m[0:100];
        drive(m, 100, 100, 100, g, se, bb, to);
        out_ready_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== m[100] || k_addr_o !== IDX_W'(101))
            $display("FAIL rstmid_pre got v=%0b d=%h a=%0d want v=1 d=%h a=101", out_valid_o, out_data_o, k_addr_o, m[100]);
        else n_pass++;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0 || k_addr_o !== '0 || out_data_o !== '0)
            $display("FAIL rstmid_post got v=%0b a=%0d d=%h want v=0 a=0 d=0", out_valid_o, k_addr_o, out_data_o);
        else n_pass++;
        out_ready_i = 1'b1;
        rand_msg(m);
        build_expected(m, e);
        drive(m, N_CW, 100, 100, g, se, bb, to);
        n_checks++;
        if (to !== 1'b0 || g.size() !== N_CW) $display("FAIL rstmid_beats got=%0d want=%0d timeout=%0b", g.size(), N_CW, to);
        else n_pass++;
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            n_checks++;
            if (g[i] !== e[i]) $display("FAIL rstmid_beat[%0d] got=%h want=%h", i, g[i], e[i]);
            else n_pass++;
        end
    endtask

`ifdef RS_ENC_CTRL_ABORT_EN
    task automatic test_abort();
        sym_t  m [$];
        beat_t e [$];
        beat_t g [$];
        int se, bb;
        bit to;
        int eops;
        rand_msg(m);
        drive(m, K_MSG + 11, 100, 100, g, se, bb, to);
        eops = 0;
        foreach (g[i]) if (g[i].eop) eops++;
        n_checks++;
        if (eops !== 0) $display("FAIL abort_no_eop got=%0d want=0", eops);
        else n_pass++;
        out_ready_i = 1'b0;
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0 || k_addr_o !== '0 || in_ready_o !== 1'b1)
            $display("FAIL abort_post got v=%0b a=%0d r=%0b want v=0 a=0 r=1", out_valid_o, k_addr_o, in_ready_o);
        else n_pass++;
        out_ready_i = 1'b1;
        rand_msg(m);
        build_expected(m, e);
        drive(m, N_CW, 100, 100, g, se, bb, to);
        n_checks++;
        if (to !== 1'b0 || g.size() !== N_CW) $display("FAIL abort_beats got=%0d want=%0d timeout=%0b", g.size(), N_CW, to);
        else n_pass++;
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            n_checks++;
            if (g[i] !== e[i]) $display("FAIL abort_beat[%0d] got=%h want=%h", i, g[i], e[i]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        build_tables();
        test_reset();
        test_all_zero();
        test_unit_msg();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef RS_ENC_CTRL_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
